// File: rtl/main_ram_ctrl_if.sv
// Request/response bus plus asynchronous SRAM pin bundle for main_ram_ctrl.
// The controller takes the slave modport; the CPU side / bench takes master.
interface main_ram_ctrl_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
  logic              _ram_cs;
  logic              _ram_oe;
  logic              _ram_w;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ram_rdata,
    output req_ready, rsp_valid, rsp_rdata, busy,
    output _ram_cs, _ram_oe, _ram_w, ram_addr, ram_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, ram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, busy,
    input  _ram_cs, _ram_oe, _ram_w, ram_addr, ram_wdata
  );
endinterface

// File: rtl/main_ram_ctrl.sv
// Sequences the async main RAM strobes from a clocked request/response bus.
// Optional MRC_POSTED_WRITE_EN adds a one-entry request buffer and posted write acks.
module main_ram_ctrl #(
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1,
  parameter int unsigned READ_CYC  = 2
) (
  input  logic           clk,
  input  logic           _reset,
  main_ram_ctrl_if.slave bus
);

  localparam int unsigned MaxAb  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned MaxCd  = (HOLD_CYC > READ_CYC) ? HOLD_CYC : READ_CYC;
  localparam int unsigned MaxCyc = (MaxAb > MaxCd) ? MaxAb : MaxCd;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  typedef enum logic [2:0] {StIdle, StRdWait, StSetup, StWrPulse, StHold} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              cs_q, cs_d, oe_q, oe_d, w_q, w_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic              rsp_valid_q, rsp_valid_d;

  logic              accept, start, start_we, last;
  logic [ADDR_W-1:0] start_addr;
  logic [DATA_W-1:0] start_wdata;

  assign last = (cnt_q == '0);

`ifdef MRC_POSTED_WRITE_EN
  localparam bit PostedWr = 1'b1;

  logic              buf_full_q, buf_full_d, buf_we_q, load_buf, rd_done;
  logic [ADDR_W-1:0] buf_addr_q;
  logic [DATA_W-1:0] buf_wdata_q;

  // No accept on a read's final edge, so its response never merges with a posted write ack.
  assign rd_done       = (state_q == StRdWait) && last;
  assign bus.req_ready = (state_q == StIdle) || (!buf_full_q && !rd_done);
  assign accept        = bus.req_valid && bus.req_ready;
  assign start         = (state_q == StIdle) && (buf_full_q || accept);
  assign load_buf      = accept && ((state_q != StIdle) || buf_full_q);
  assign buf_full_d    = load_buf || (buf_full_q && (state_q != StIdle));
  assign start_we      = buf_full_q ? buf_we_q    : bus.req_we;
  assign start_addr    = buf_full_q ? buf_addr_q  : bus.req_addr;
  assign start_wdata   = buf_full_q ? buf_wdata_q : bus.req_wdata;
  assign bus.busy      = (state_q != StIdle) || buf_full_q;

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      buf_full_q  <= 1'b0;
      buf_we_q    <= 1'b0;
      buf_addr_q  <= '0;
      buf_wdata_q <= '0;
    end else begin
      buf_full_q <= buf_full_d;
      if (load_buf) begin
        buf_we_q    <= bus.req_we;
        buf_addr_q  <= bus.req_addr;
        buf_wdata_q <= bus.req_wdata;
      end
    end
  end
`else
  localparam bit PostedWr = 1'b0;

  assign bus.req_ready = (state_q == StIdle);
  assign accept        = bus.req_valid && bus.req_ready;
  assign start         = accept;
  assign start_we      = bus.req_we;
  assign start_addr    = bus.req_addr;
  assign start_wdata   = bus.req_wdata;
  assign bus.busy      = (state_q != StIdle);
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cs_d        = cs_q;
    oe_d        = oe_q;
    w_d         = w_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = PostedWr && accept && bus.req_we;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = start_addr;
          wdata_d = start_wdata;
          cs_d    = 1'b0;
          if (start_we) begin
            state_d = StSetup;
            cnt_d   = CntW'(SETUP_CYC - 1);
          end else begin
            state_d = StRdWait;
            oe_d    = 1'b0;
            cnt_d   = CntW'(READ_CYC - 1);
          end
        end
      end
      StRdWait: begin
        if (last) begin
          rdata_d     = bus.ram_rdata;
          rsp_valid_d = 1'b1;
          cs_d        = 1'b1;
          oe_d        = 1'b1;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StSetup: begin
        if (last) begin
          w_d     = 1'b0;
          state_d = StWrPulse;
          cnt_d   = CntW'(PULSE_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWrPulse: begin
        if (last) begin
          w_d     = 1'b1;
          state_d = StHold;
          cnt_d   = CntW'(HOLD_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHold: begin
        if (last) begin
          cs_d    = 1'b1;
          state_d = StIdle;
          if (!PostedWr) rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cs_q        <= 1'b1;
      oe_q        <= 1'b1;
      w_q         <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cs_q        <= cs_d;
      oe_q        <= oe_d;
      w_q         <= w_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus._ram_cs   = cs_q;
  assign bus._ram_oe   = oe_q;
  assign bus._ram_w    = w_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;

endmodule
